// File: rtl/gomoku_pkg.sv
// Shared button definitions: count, index constants and the packed button vector type.
package gomoku_pkg;

  localparam int unsigned NUM_BTNS = 5;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_bit.sv
// One button lane: 2-flop synchronizer, stability counter, debounced level and press pulse.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic level_next_c
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after sync2 disagrees with it for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      lvl_d   = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level_o      = lvl_q;
  assign press_o      = press_q;
  assign level_next_c = lvl_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces five raw buttons into levels and one-cycle press pulses.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat on the four direction buttons.
module button_conditioner
  import gomoku_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  btn_vec_t btn_raw,
  output logic     up,
  output logic     down,
  output logic     left,
  output logic     right,
  output logic     center,
  output btn_vec_t btn_level
);

  btn_vec_t press;
  btn_vec_t level_next;
  btn_vec_t rep;
  btn_vec_t pulse;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw_i       (btn_raw[i]),
      .level_o     (btn_level[i]),
      .press_o     (press[i]),
      .level_next_c(level_next[i])
    );
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_rpt
    if (i != BTN_CENTER) begin : g_dir
      logic [RW-1:0] cnt_q, cnt_d;
      logic          periodic_q, periodic_d;
      logic          rep_q, rep_d;
      logic [RW-1:0] lim;

      assign lim = periodic_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

      // Counts cycles since the last pulse while held; a pulse due in the release cycle is dropped.
      always_comb begin
        cnt_d      = cnt_q;
        periodic_d = periodic_q;
        rep_d      = 1'b0;
        if (!btn_level[i]) begin
          cnt_d      = '0;
          periodic_d = 1'b0;
        end else if (cnt_q == lim) begin
          cnt_d      = '0;
          periodic_d = 1'b1;
          rep_d      = level_next[i];
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q      <= '0;
          periodic_q <= 1'b0;
          rep_q      <= 1'b0;
        end else begin
          cnt_q      <= cnt_d;
          periodic_q <= periodic_d;
          rep_q      <= rep_d;
        end
      end

      assign rep[i] = rep_q;
    end else begin : g_ctr
      assign rep[i] = 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = level_next[BTN_CENTER];
`else
  logic unused_ok;
  assign unused_ok = ^{level_next, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep       = '0;
`endif

  assign pulse  = press | rep;
  assign up     = pulse[BTN_UP];
  assign down   = pulse[BTN_DOWN];
  assign left   = pulse[BTN_LEFT];
  assign right  = pulse[BTN_RIGHT];
  assign center = pulse[BTN_CENTER];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic       up, down, left, right, center;
  logic [4:0] btn_level;
  logic [4:0] obs;

  int checks;
  int failures;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .center   (center),
    .btn_level(btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {center, right, left, down, up};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pulse for a button whose press pulse lands at edge pk and whose raw drops after edge rel.
  function automatic logic exp_pulse(int i, int k, int pk, int rel);
    logic p;
    p = (k == pk);
    if (AUTOREP && i != 4 && k >= pk + int'(RD) && k < rel + 6 &&
        ((k - pk - int'(RD)) % int'(RP)) == 0)
      p = 1'b1;
    return p;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = 5'h1F;
    repeat (3) tick();
    checks++;
    if (obs !== 5'h00) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected %b", obs, 5'h00);
    end
    checks++;
    if (btn_level !== 5'h00) begin
      failures++;
      $display("FAIL reset_level: got %b expected %b", btn_level, 5'h00);
    end
    btn_raw = 5'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs !== 5'h00 || btn_level !== 5'h00) begin
      failures++;
      $display("FAIL post_reset_idle: got pulses %b level %b expected 0", obs, btn_level);
    end
  endtask

  // Hold the buttons in mask from edge 0 and drop them after edge rel.
  task automatic test_hold(input logic [4:0] mask, input int rel, input string name);
    logic [4:0] ep, el;
    btn_raw = mask;
    for (int k = 0; k <= rel + 8; k++) begin
      tick();
      for (int i = 0; i < 5; i++) begin
        ep[i] = mask[i] & exp_pulse(i, k, int'(DC) + 1, rel);
        el[i] = mask[i] & (k >= int'(DC) + 1 && k < rel + 6);
      end
      checks++;
      if (obs !== ep) begin
        failures++;
        $display("FAIL %s_pulse edge %0d: got %b expected %b", name, k, obs, ep);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL %s_level edge %0d: got %b expected %b", name, k, btn_level, el);
      end
      if (k == rel) btn_raw = 5'h00;
    end
  endtask

  task automatic test_glitch();
    btn_raw = 5'b00100;
    for (int k = 0; k <= 12; k++) begin
      tick();
      checks++;
      if (obs !== 5'h00 || btn_level !== 5'h00) begin
        failures++;
        $display("FAIL glitch edge %0d: got pulses %b level %b expected 0", k, obs, btn_level);
      end
      if (k == 2) btn_raw = 5'h00;
    end
  endtask

  task automatic test_bounce();
    logic ep, el;
    btn_raw = 5'b00001;
    for (int k = 0; k <= 20; k++) begin
      tick();
      ep = exp_pulse(0, k, 5, 12);
      el = (k >= 5 && k < 18);
      checks++;
      if (obs !== {4'b0000, ep}) begin
        failures++;
        $display("FAIL bounce_pulse edge %0d: got %b expected %b", k, obs, {4'b0000, ep});
      end
      checks++;
      if (btn_level !== {4'b0000, el}) begin
        failures++;
        $display("FAIL bounce_level edge %0d: got %b expected %b", k, btn_level, {4'b0000, el});
      end
      if (k == 7)  btn_raw = 5'b00000;
      if (k == 9)  btn_raw = 5'b00001;
      if (k == 12) btn_raw = 5'b00000;
    end
  endtask

  // Reset sampled low at edges 3 and 4 while up is held; press lands at edge 10.
  task automatic test_reset_mid_press();
    logic ep, el;
    btn_raw = 5'b00001;
    for (int k = 0; k <= 24; k++) begin
      tick();
      ep = exp_pulse(0, k, 10, 16);
      el = (k >= 10 && k < 22);
      checks++;
      if (obs !== {4'b0000, ep}) begin
        failures++;
        $display("FAIL rst_mid_pulse edge %0d: got %b expected %b", k, obs, {4'b0000, ep});
      end
      checks++;
      if (btn_level !== {4'b0000, el}) begin
        failures++;
        $display("FAIL rst_mid_level edge %0d: got %b expected %b", k, btn_level, {4'b0000, el});
      end
      if (k == 2)  rst_n = 1'b0;
      if (k == 4)  rst_n = 1'b1;
      if (k == 16) btn_raw = 5'b00000;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn_raw  = 5'h00;
    test_reset();
    test_hold(5'b00001, 12, "up_press");
    test_glitch();
    test_hold(5'b11000, 8, "center_right");
    test_reset_mid_press();
    test_hold(5'b00010, 30, "down_hold");
    test_hold(5'b10000, 30, "center_hold");
    test_bounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
